// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage
// ----------------------------------------------------------------------------
// Decode-to-execute pipeline register for a non-forwarding RV32I core.
//
//  * Selects the ALU operands before the register (rs1 or PC for A, rs2 or
//    immediate for B) so operand_a_o/operand_b_o feed the ALU directly.
//  * Carries the execute/memory/writeback control of the EX instruction.
//  * Owns the scoreboard interlock: one pending bit per architectural
//    register, set when a writer issues into EX and cleared when writeback
//    retires it. Decode is stalled on RAW and WAW hazards, and a bubble is
//    loaded into EX while it waits.
//
// Per-cycle priority: stall_i (hold) > flush_i (bubble) > hazard (bubble and
// stall decode) > issue.
//
// Build option:
//   ID_EX_WB_BYPASS_EN  when defined, the register being written back in the
//                       current cycle is masked out of the hazard check. This
//                       is only safe with a write-first register file and
//                       saves one stall cycle per RAW hazard. Undefined
//                       (default), the hazard check uses the raw scoreboard
//                       and a cleared bit is first visible the next cycle.
// ============================================================================

module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  // Decode-side instruction
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wren_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            op_a_sel_i,
  input  logic            op_b_sel_i,
  input  logic [3:0]      alu_op_i,
  input  logic [7:0]      ctrl_i,

  // Pipeline control
  input  logic            stall_i,
  input  logic            flush_i,

  // Writeback retirement (clears scoreboard bits)
  input  logic            wb_wren_i,
  input  logic [4:0]      wb_rd_addr_i,

  // Execute-side outputs
  output logic            ex_valid_o,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wren_o,
  output logic [7:0]      ctrl_o,

  // Decode hold request
  output logic            id_stall_o
);

  // --------------------------------------------------------------------------
  // EX payload: everything that travels with the instruction into execute.
  // An all-zero payload is a bubble.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_addr;
    logic            rd_wren;
    logic [7:0]      ctrl;
  } ex_payload_t;

  ex_payload_t     ex_q, ex_d;
  ex_payload_t     id_payload;

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] pending_eff;

  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            rd_hazard;
  logic            hazard;
  logic            issue;
  logic            sb_set;
  logic            sb_clear;

  // --------------------------------------------------------------------------
  // Scoreboard view used by the hazard check (optionally bypassing the
  // register that writeback is retiring this cycle).
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // assignment first, so no path leaves it unassigned and no latch is
    // inferred.
    pending_eff = pending_q;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_wren_i) begin
      pending_eff[wb_rd_addr_i] = 1'b0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Hazard detection: RAW on each used source, WAW on the destination.
  // x0 is hardwired to zero, so it is excluded explicitly.
  // --------------------------------------------------------------------------
  always_comb begin
    rs1_hazard = rs1_used_i && (rs1_addr_i != 5'd0) && pending_eff[rs1_addr_i];
    rs2_hazard = rs2_used_i && (rs2_addr_i != 5'd0) && pending_eff[rs2_addr_i];
    rd_hazard  = rd_wren_i  && (rd_addr_i  != 5'd0) && pending_eff[rd_addr_i];
    hazard     = id_valid_i && (rs1_hazard || rs2_hazard || rd_hazard);
  end

  // --------------------------------------------------------------------------
  // Pipeline decisions: issue only when nothing of higher priority applies.
  // Decode must hold on a downstream stall, or on a hazard that is not being
  // overridden by a flush (a flushed instruction is dropped, not held).
  // --------------------------------------------------------------------------
  always_comb begin
    issue      = id_valid_i && !stall_i && !flush_i && !hazard;
    id_stall_o = stall_i || (!flush_i && hazard);
  end

  // --------------------------------------------------------------------------
  // Operand selection ahead of the register, so EX sees ALU-ready operands.
  // --------------------------------------------------------------------------
  always_comb begin
    id_payload           = '0;
    id_payload.valid     = 1'b1;
    id_payload.operand_a = op_a_sel_i ? id_pc_i : rs1_data_i;
    id_payload.operand_b = op_b_sel_i ? imm_i   : rs2_data_i;
    id_payload.alu_op    = alu_op_i;
    id_payload.rs2_data  = rs2_data_i;
    id_payload.pc        = id_pc_i;
    id_payload.rd_addr   = rd_addr_i;
    id_payload.rd_wren   = rd_wren_i;
    id_payload.ctrl      = ctrl_i;
  end

  // --------------------------------------------------------------------------
  // Next EX contents: hold on stall, otherwise the issued instruction or a
  // bubble (flush, hazard, or no valid decode instruction).
  // --------------------------------------------------------------------------
  always_comb begin
    ex_d = ex_q;
    if (!stall_i) begin
      ex_d = issue ? id_payload : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Next scoreboard: clear on writeback, then set on issue so that a set and
  // a clear of the same register in one cycle leaves it pending.
  // --------------------------------------------------------------------------
  always_comb begin
    sb_clear  = wb_wren_i && (wb_rd_addr_i != 5'd0);
    sb_set    = issue && rd_wren_i && (rd_addr_i != 5'd0);
    pending_d = pending_q;
    if (sb_clear) begin
      pending_d[wb_rd_addr_i] = 1'b0;
    end
    if (sb_set) begin
      pending_d[rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // State registers: EX payload and scoreboard, both cleared by reset so that
  // any in-flight pending bit is discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst_ni) begin
      ex_q      <= '0;
      pending_q <= '0;
    end else begin
      ex_q      <= ex_d;
      pending_q <= pending_d;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs.
  // --------------------------------------------------------------------------
  assign ex_valid_o  = ex_q.valid;
  assign operand_a_o = ex_q.operand_a;
  assign operand_b_o = ex_q.operand_b;
  assign alu_op_o    = ex_q.alu_op;
  assign rs2_data_o  = ex_q.rs2_data;
  assign pc_o        = ex_q.pc;
  assign rd_addr_o   = ex_q.rd_addr;
  assign rd_wren_o   = ex_q.rd_wren;
  assign ctrl_o      = ex_q.ctrl;

endmodule
